stopwatch_counter: RTL
======================

# stopwatch_counter

Stopwatch datapath and control for the digital clock. It sits directly downstream of the mode-select FSM and consumes its `STOPWATCH_RUN` output as the button-ownership enable. It counts MM:SS.cc in BCD from a prescaled system clock and supports start/stop, lap-hold and clear. Its BCD digits feed the display mux.

## Interface
- `CLK_DIV`, default 10000: clock cycles per 1/100 s tick (10000 at 1 MHz). Must be ≥2.
- `clock` input 1: system clock, all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `STOPWATCH_RUN` input 1: stopwatch mode active; the block acts on button events only while this is 1.
- `SW_START` input 1: debounced start/stop button, level.
- `SW_CLEAR` input 1: debounced lap/clear button, level.
- `SW_MIN_T`, `SW_MIN_U` output 4: displayed minutes, BCD tens/units.
- `SW_SEC_T`, `SW_SEC_U` output 4: displayed seconds, BCD tens/units.
- `SW_CS_T`, `SW_CS_U` output 4: displayed centiseconds, BCD tens/units.
- `SW_RUNNING` output 1: 1 in RUNNING or LAP.
- `SW_LAP` output 1: 1 in LAP (display frozen).
- `SW_OVF` output 1: one-cycle pulse on wrap 59:59.99 → 00:00.00.

## Operation
- **Edge detect.** A previous-value flop is kept per button; event = `in & ~prev`. One event is produced per 0→1 transition. Events are discarded when `STOPWATCH_RUN`=0; the edge flops still track the inputs.
- **Simultaneous events.** If START and CLEAR events occur on the same cycle, START is taken and CLEAR is dropped.
- **CLEARED state.** Count = 0, prescaler = 0. START → RUNNING. CLEAR is ignored.
- **RUNNING state.** Prescaler and count advance.
  - START → STOPPED.
  - CLEAR → LAP. On the same edge, the lap registers load the current count (the pre-increment value if a tick coincides).
- **LAP state.** Count keeps advancing, but the outputs show the lap registers.
  - CLEAR → RUNNING, display live again.
  - START → STOPPED, display live and showing the stopped count.
- **STOPPED state.** Prescaler and count hold.
  - START → RUNNING; the prescaler resumes from its held value.
  - CLEAR → CLEARED; count and prescaler zero on that edge.
- **Prescaler.**
  - Counts 0..CLK_DIV-1 in RUNNING/LAP only.
  - tick = (prescaler == CLK_DIV-1) while counting; on tick the prescaler wraps to 0.
- **BCD count.** Increments by 0.01 s per tick with digit carries:
  - cs units 9→0, carrying into cs tens;
  - cs 99→00 carries into sec;
  - sec 59→00 carries into min;
  - min 59→00 is the wrap and asserts `SW_OVF` for that cycle.
- **Digit ranges.** Tens digits of sec/min never exceed 5; no digit ever holds 10–15.
- **Outputs.** Display = lap registers when in LAP, otherwise live count. All outputs are driven from flops or a state-decoded mux; there are no combinational paths from the button inputs.
- **Mode exit.** When `STOPWATCH_RUN` drops mid-run, counting continues in the background and the state is retained.

## Timing
- **Reset (async, `reset`=0).**
  - State = CLEARED.
  - All digits = 0; lap registers = 0; prescaler = 0.
  - `SW_RUNNING`=0, `SW_LAP`=0, `SW_OVF`=0.
  - Edge flops = 1, so a button held through reset release produces no event.
- **Event latency.** A button high at clock edge N, having been low at edge N-1, changes state at edge N. Outputs reflect the new state after edge N.
- **Tick spacing.** The first tick after CLEARED → RUNNING occurs CLK_DIV cycles after the transition edge; subsequent ticks are every CLK_DIV cycles while counting.
- **Run time.** Full run 00:00.00 → 59:59.99 → wrap takes 360000 ticks.
- **Mid-operation reset.** Reset asserted mid-operation returns to the reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset and held button.** Reset with `SW_START`=1 held through release, `STOPWATCH_RUN`=1 → state stays CLEARED, all digits 0, `SW_RUNNING`=0.
- **Start/stop/resume (CLK_DIV=4).** START pulse, run 40 cycles → display 00:00.10. START stops the count; 20 more cycles → still 00:00.10. START again, 8 cycles → 00:00.12.
- **Lap.** While RUNNING at 00:00.05, CLEAR → `SW_LAP`=1 and display frozen at 00:00.05. After 12 cycles, CLEAR → display live at 00:00.08.
- **Clear.** In STOPPED at 00:01.37, CLEAR → all digits 0, state CLEARED. A CLEAR in CLEARED causes no change.
- **Mode gating and collision.**
  - `STOPWATCH_RUN`=0 with START pulses → no state change.
  - START and CLEAR rising on the same edge while RUNNING → STOPPED, `SW_LAP`=0.
- **Wrap.** Preload to 59:59.99 by forcing or by running with CLK_DIV=2, then one tick → 00:00.00, `SW_OVF` high for exactly 1 cycle, `SW_RUNNING` stays 1.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS.cc BCD stopwatch with start/stop, lap-hold and clear.
module stopwatch_counter #(
  parameter int CLK_DIV = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       STOPWATCH_RUN,
  input  logic       SW_START,
  input  logic       SW_CLEAR,
  output logic [3:0] SW_MIN_T,
  output logic [3:0] SW_MIN_U,
  output logic [3:0] SW_SEC_T,
  output logic [3:0] SW_SEC_U,
  output logic [3:0] SW_CS_T,
  output logic [3:0] SW_CS_U,
  output logic       SW_RUNNING,
  output logic       SW_LAP,
  output logic       SW_OVF
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [23:0] MAX = 24'h595999;
  typedef enum logic [1:0] {CLEARED, RUNNING, LAP, STOPPED} state_t;
  state_t state_q, state_d;
  logic start_prev_q, clear_prev_q, ovf_q, ovf_d;
  logic start_ev, clear_ev, counting, tick, wrap, clr;
  logic [PW-1:0] pre_q, pre_d;
  logic [23:0] cnt_q, cnt_d, lap_q, lap_d, cnt_inc;
  logic [6:0] cy;
  assign start_ev = STOPWATCH_RUN & SW_START & ~start_prev_q;
  assign clear_ev = STOPWATCH_RUN & SW_CLEAR & ~clear_prev_q & ~start_ev;
  assign counting = state_q == RUNNING || state_q == LAP;
  assign tick     = counting && pre_q == PW'(CLK_DIV - 1);
  assign clr      = clear_ev && state_q == STOPPED;
  // Digits from cs units (0) to min tens (5); each rolls at its own maximum.
  always_comb begin
    cy[0] = 1'b1;
    cnt_inc = cnt_q;
    for (int i = 0; i < 6; i++) begin
      cnt_inc[4*i +: 4] = !cy[i] ? cnt_q[4*i +: 4] : cnt_q[4*i +: 4] == MAX[4*i +: 4] ? 4'd0 : cnt_q[4*i +: 4] + 4'd1;
      cy[i+1] = cy[i] && cnt_q[4*i +: 4] == MAX[4*i +: 4];
    end
    wrap = cy[6];
  end
  always_comb begin
    state_d = start_ev ? (counting ? STOPPED : RUNNING) :
              clear_ev ? (state_q == RUNNING ? LAP : state_q == LAP ? RUNNING : CLEARED) : state_q;
    pre_d   = clr ? '0 : !counting ? pre_q : tick ? '0 : pre_q + PW'(1);
    cnt_d   = clr ? '0 : tick ? cnt_inc : cnt_q;
    lap_d   = clear_ev && state_q == RUNNING ? cnt_q : lap_q;
    ovf_d   = tick & wrap;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEARED;
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
      pre_q        <= '0;
      cnt_q        <= '0;
      lap_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= SW_START;
      clear_prev_q <= SW_CLEAR;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      lap_q        <= lap_d;
      ovf_q        <= ovf_d;
    end
  end
  assign {SW_MIN_T, SW_MIN_U, SW_SEC_T, SW_SEC_U, SW_CS_T, SW_CS_U} = state_q == LAP ? lap_q : cnt_q;
  assign SW_RUNNING = counting;
  assign SW_LAP     = state_q == LAP;
  assign SW_OVF     = ovf_q;
endmodule
